sdram_byte_bridge: RTL
======================

// Module: sdram_byte_bridge
// PURPOSE
//  Upstream front-end for the 16-bit SDRAM controller: turns 8-bit CPU byte reads/writes into its
//  edge-triggered word interface (sd_rd rising = read, sd_we_n falling = write).
//  Controller has DQM tied low, so byte writes are done as read-modify-write.
//  Sole client of the controller; sits between CPU bus decode and the controller.
// PARAMETERS
//  RD_WAIT  10  cycles sd_rd held high; sd_rdata captured on the last one (>=9: refresh + RAS/CAS)
//  WR_WAIT   8  cycles sd_we_n held low (>=8)
//  GAP       4  cycles strobe held inactive after each op, so controller IDLE sees deassert (>=3)
// PORTS
//  clk50mhz   in   1   clock, 50 MHz
//  reset      in   1   synchronous, active-high
//  cpu_addr   in   23  byte address; [22:1] word address, [0] lane (0=[7:0], 1=[15:8])
//  cpu_wdata  in   8   write byte
//  cpu_rd     in   1   read request, level, held until cpu_ready
//  cpu_wr     in   1   write request, level, held until cpu_ready
//  cpu_rdata  out  8   read byte, valid with cpu_ready, then held
//  cpu_ready  out  1   one-cycle completion pulse
//  sd_addr    out  22  word address to controller iaddr
//  sd_wdata   out  16  word to controller idata
//  sd_rd      out  1   controller rd
//  sd_we_n    out  1   controller we_n
//  sd_rdata   in   16  controller odata
// BEHAVIOUR
//  Reset: state IDLE, sd_rd=0, sd_we_n=1, cpu_ready=0, cpu_rdata=0, sd_addr=0, sd_wdata=0, cnt=0.
//   Reset mid-op aborts immediately; strobes are inactive from the next cycle.
//  All outputs registered. cnt is 4 bits, loaded with WAIT-1 on state entry, decrements, exits at 0.
//  FSM:
//   IDLE:   cpu_wr -> latch addr/wdata/lane, RD_REQ with op=WR. Else cpu_rd -> RD_REQ with op=RD.
//           If both are high, write wins.
//   RD_REQ: sd_rd=1 for RD_WAIT cycles; at exit, word<=sd_rdata -> RD_GAP.
//   RD_GAP: sd_rd=0 for GAP cycles. op=RD -> DONE. op=WR -> build merged word
//           (selected lane <= wdata, other lane from word), sd_wdata<=merged -> WR_REQ.
//   WR_REQ: sd_we_n=0 for WR_WAIT cycles -> WR_GAP.
//   WR_GAP: sd_we_n=1 for GAP cycles -> DONE.
//   DONE:   cpu_ready=1 for one cycle; cpu_rdata<=selected lane of word (reads only) -> REL.
//   REL:    wait until cpu_rd=0 and cpu_wr=0 -> IDLE. No re-trigger on held requests.
//  sd_addr and sd_wdata are stable for the whole op; the controller latches them at its IDLE sample.
//  sd_rd and sd_we_n are never active together.
//  Latency, request-to-ready: read 1+RD_WAIT+GAP+1 = 16; write 16+WR_WAIT+GAP = 28 (defaults).
//  Requests arriving outside IDLE are ignored until REL->IDLE.
// CONFIGURATION
//  SDRAM_WORD_CACHE_EN defined: one-entry word cache (tag[21:0], data[15:0], valid).
//   Read hit in IDLE goes straight to DONE (ready 2 cycles after request).
//   Write hit skips RD_REQ/RD_GAP: merge from cache, go to WR_REQ.
//   Any completed read or write loads/updates the entry with the full word.
//   reset clears valid.
//  Not defined: every access goes through the SDRAM; no cache registers exist.
// STRUCTURE
//  Package sdram_bridge_pkg: state encoding (IDLE,RD_REQ,RD_GAP,WR_REQ,WR_GAP,DONE,REL),
//   op encoding, lane-merge function, default wait constants.
//  Sub-module sdram_word_cache (tag/data/valid, hit compare, update port); instantiated only
//   under SDRAM_WORD_CACHE_EN.
// TESTING  (bench: real SDRAM controller plus SDRAM model, or a cycle-exact model of it)
//  1 Preload word 0x1234 @0x000010. Read byte 0x000020 -> cpu_rdata=0x34.
//    Read 0x000021 -> 0x12. Ready 16 cycles after request.
//  2 Write 0xAB to byte 0x000021 over 0x1234 -> SDRAM word 0xAB34; sd_we_n low exactly 8 cycles.
//  3 Raise cpu_rd and cpu_wr together -> write performed; one cpu_ready pulse only.
//  4 Force controller refresh coincident with sd_rd rising -> data still correct, latency unchanged.
//  5 Hold cpu_rd high 40 cycles after ready -> exactly one read issued (stays in REL).
//  6 Assert reset during WR_REQ -> next cycle sd_we_n=1, sd_rd=0, cpu_ready=0.
//    With CACHE_EN: repeat read of case 1 -> ready in 2 cycles, no sd_rd edge.

Source files
------------

// File: rtl/sdram_bridge_pkg.sv
// Shared definitions for the SDRAM byte bridge: FSM and op encodings,
// default strobe timing, and byte-lane helpers used by the bridge and cache.
package sdram_bridge_pkg;

  // Default timing in clk50mhz cycles. RD_WAIT covers a refresh plus RAS/CAS
  // in the controller; GAP lets the controller's IDLE state see the deassert.
  localparam int RD_WAIT_DEF = 10;
  localparam int WR_WAIT_DEF = 8;
  localparam int GAP_DEF     = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_GAP = 3'd2,
    WR_REQ = 3'd3,
    WR_GAP = 3'd4,
    DONE   = 3'd5,
    REL    = 3'd6
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Replace one byte lane of a word; lane 0 is [7:0], lane 1 is [15:8].
  function automatic logic [15:0] lane_merge(input logic [15:0] word,
                                             input logic        lane,
                                             input logic [7:0]  data);
    logic [15:0] merged;
    merged = word;
    if (lane) merged[15:8] = data;
    else      merged[7:0]  = data;
    return merged;
  endfunction

  // Pick one byte lane out of a word.
  function automatic logic [7:0] lane_select(input logic [15:0] word,
                                             input logic        lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sdram_word_cache.sv
// One-entry word cache in front of the SDRAM: a single tag/data/valid set,
// combinational hit compare and a one-cycle update port. Only built when
// SDRAM_WORD_CACHE_EN is defined in the bridge.
module sdram_word_cache (
  input  logic        clk50mhz,
  input  logic        reset,
  input  logic [21:0] lookup_addr,
  output logic        hit,
  output logic [15:0] hit_data,
  input  logic        upd_en,
  input  logic [21:0] upd_addr,
  input  logic [15:0] upd_data
);

  logic [21:0] tag;
  logic [15:0] data;
  logic        valid;

  // Entry storage: reset invalidates, an update overwrites the whole word.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (upd_en) begin
      tag   <= upd_addr;
      data  <= upd_data;
      valid <= 1'b1;
    end
  end

  // Hit when the stored word address matches the lookup.
  always_comb begin
    hit      = valid && (tag == lookup_addr);
    hit_data = data;
  end

endmodule

// File: rtl/sdram_byte_bridge.sv
// CPU byte bus to 16-bit SDRAM controller bridge. Reads issue one sd_rd
// pulse; writes are read-modify-write because the controller has DQM tied
// low. Every output is registered. Define SDRAM_WORD_CACHE_EN to add a
// one-entry word cache that short-circuits repeat accesses to one word.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  IDLE   | waiting for cpu_rd / cpu_wr (write wins when both are high)
//  RD_REQ | sd_rd held high RD_WAIT cycles, word captured on the last
//  RD_GAP | sd_rd low GAP cycles; writes merge the byte here
//  WR_REQ | sd_we_n held low WR_WAIT cycles
//  WR_GAP | sd_we_n high GAP cycles
//  DONE   | cpu_ready pulse, read byte presented
//  REL    | wait for the CPU to drop its request
module sdram_byte_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic        clk50mhz,
  input  logic        reset,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [21:0] sd_addr,
  output logic [15:0] sd_wdata,
  output logic        sd_rd,
  output logic        sd_we_n,
  input  logic [15:0] sd_rdata
);

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  state_t           state, state_nxt;
  op_t              op, op_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lane, lane_nxt;
  logic [7:0]       wbyte, wbyte_nxt;
  logic [15:0]      word, word_nxt;

  logic [21:0]      sd_addr_nxt;
  logic [15:0]      sd_wdata_nxt;
  logic             sd_rd_nxt, sd_we_n_nxt;
  logic             cpu_ready_nxt;
  logic [7:0]       cpu_rdata_nxt;

  logic             cache_hit;
  logic [15:0]      cache_data;

`ifdef SDRAM_WORD_CACHE_EN
  // The entry is refreshed with the full word as each access completes.
  logic cache_upd;
  assign cache_upd = (state == DONE);

  sdram_word_cache u_cache (
    .clk50mhz    (clk50mhz),
    .reset       (reset),
    .lookup_addr (cpu_addr[22:1]),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .upd_en      (cache_upd),
    .upd_addr    (sd_addr),
    .upd_data    (word)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  // State register.
  always_ff @(posedge clk50mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath and registered outputs; reset drops strobes on the next cycle.
  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      op        <= OP_RD;
      cnt       <= '0;
      lane      <= 1'b0;
      wbyte     <= '0;
      word      <= '0;
      sd_addr   <= '0;
      sd_wdata  <= '0;
      sd_rd     <= 1'b0;
      sd_we_n   <= 1'b1;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      op        <= op_nxt;
      cnt       <= cnt_nxt;
      lane      <= lane_nxt;
      wbyte     <= wbyte_nxt;
      word      <= word_nxt;
      sd_addr   <= sd_addr_nxt;
      sd_wdata  <= sd_wdata_nxt;
      sd_rd     <= sd_rd_nxt;
      sd_we_n   <= sd_we_n_nxt;
      cpu_ready <= cpu_ready_nxt;
      cpu_rdata <= cpu_rdata_nxt;
    end
  end

  // Next-state and next-output logic; counters load WAIT-1 on state entry.
  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    cnt_nxt       = cnt;
    lane_nxt      = lane;
    wbyte_nxt     = wbyte;
    word_nxt      = word;
    sd_addr_nxt   = sd_addr;
    sd_wdata_nxt  = sd_wdata;
    sd_rd_nxt     = sd_rd;
    sd_we_n_nxt   = sd_we_n;
    cpu_ready_nxt = 1'b0;
    cpu_rdata_nxt = cpu_rdata;

    unique case (state)
      IDLE: begin
        if (cpu_wr || cpu_rd) begin
          op_nxt      = cpu_wr ? OP_WR : OP_RD;
          sd_addr_nxt = cpu_addr[22:1];
          lane_nxt    = cpu_addr[0];
          wbyte_nxt   = cpu_wdata;
          if (cache_hit && cpu_wr) begin
            word_nxt     = lane_merge(cache_data, cpu_addr[0], cpu_wdata);
            sd_wdata_nxt = word_nxt;
            sd_we_n_nxt  = 1'b0;
            cnt_nxt      = WR_LOAD;
            state_nxt    = WR_REQ;
          end else if (cache_hit) begin
            word_nxt  = cache_data;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            sd_rd_nxt = 1'b1;
            cnt_nxt   = RD_LOAD;
            state_nxt = RD_REQ;
          end
        end
      end

      RD_REQ: begin
        if (cnt == '0) begin
          word_nxt  = sd_rdata;
          sd_rd_nxt = 1'b0;
          cnt_nxt   = GAP_LOAD;
          state_nxt = RD_GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      RD_GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (op == OP_WR) begin
          word_nxt     = lane_merge(word, lane, wbyte);
          sd_wdata_nxt = word_nxt;
          sd_we_n_nxt  = 1'b0;
          cnt_nxt      = WR_LOAD;
          state_nxt    = WR_REQ;
        end else begin
          state_nxt = DONE;
        end
      end

      WR_REQ: begin
        if (cnt == '0) begin
          sd_we_n_nxt = 1'b1;
          cnt_nxt     = GAP_LOAD;
          state_nxt   = WR_GAP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      WR_GAP: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end

      DONE: begin
        cpu_ready_nxt = 1'b1;
        if (op == OP_RD) cpu_rdata_nxt = lane_select(word, lane);
        state_nxt = REL;
      end

      REL: begin
        if (!cpu_rd && !cpu_wr) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
